wptr_full_level: RTL and testbench
==================================

Name: wptr_full_level

Overview:
- Write-side pointer and flag generator for the async FIFO, generalised from the basic write-pointer/full block.
- Keeps binary and gray write pointers and a registered full flag.
- Adds a fill-level count, a programmable almost-full flag and a sticky overflow flag, all derived from the synchronised gray read pointer.
- Sits in the write clock domain between the write client, the dual-port RAM write port and the read-to-write pointer synchroniser.

Parameters:
- ADDRSIZE, 4, RAM address width; FIFO depth DEPTH = 2**ADDRSIZE; pointers are ADDRSIZE+1 bits.
- AFULL_RST, 2**ADDRSIZE-2, reset value of the internal almost-full threshold register.

Ports:
- wclk  in  1  write-domain clock; all state updates on its rising edge.
- wrst  in  1  asynchronous active-high reset, write domain.
- winc  in  1  write request; accepted only when wfull=0.
- wq2_rptr  in  ADDRSIZE+1  read pointer, gray-coded, already synchronised to wclk.
- wafull_thresh  in  ADDRSIZE+1  almost-full threshold, sampled when wthresh_ld=1.
- wthresh_ld  in  1  loads wafull_thresh into the threshold register.
- wovf_clr  in  1  clears woverflow.
- wfull  out  1  FIFO full, registered.
- wafull  out  1  level >= threshold, registered.
- wlevel  out  ADDRSIZE+1  entries held from the write side's view, 0..DEPTH, registered.
- woverflow  out  1  sticky: a write was attempted while full.
- waddr  out  ADDRSIZE  RAM write address = wbin[ADDRSIZE-1:0].
- wptr  out  ADDRSIZE+1  gray write pointer, registered, sent to the read-domain synchroniser.

Behaviour:
- Reset (wrst=1, asynchronous):
  - wbin, wptr, wlevel, wfull, wafull, woverflow all 0.
  - Threshold register = AFULL_RST.
  - All inputs are ignored while wrst is high.
  - Deassertion takes effect on the next wclk edge.
- Write accept: wacc = winc & ~wfull.
  - wbinnext = wbin + wacc, modulo 2**(ADDRSIZE+1); wraps from 2*DEPTH-1 to 0.
  - wgraynext = (wbinnext>>1) ^ wbinnext.
  - Every edge: wbin <= wbinnext, wptr <= wgraynext.
- Read pointer decode: rbin = gray-to-binary(wq2_rptr), combinational, ADDRSIZE+1 bits. Each bit is the XOR of all higher gray bits.
- Level: levnext = (wbinnext - rbin) mod 2**(ADDRSIZE+1); wlevel <= levnext every edge.
- Full: wfull <= (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]}), equivalently levnext == DEPTH.
- Almost-full: wafull <= (levnext >= thr), unsigned compare.
  - thr=0 gives wafull=1 on every edge after reset.
  - thr > DEPTH gives wafull permanently 0.
- Threshold register: thr <= wafull_thresh when wthresh_ld=1. The new value is used in the compare from the following edge onward.
- Latency: a write accepted at edge N advances waddr/wptr and updates wlevel/wfull/wafull at edge N. Flags and level therefore describe the state after that write.
- A read pointer change on wq2_rptr is reflected in wlevel/wfull/wafull at the next edge.
- Write while full: winc=1 with wfull=1 is dropped and the pointers hold. woverflow <= 1.
- woverflow stays 1 until wovf_clr=1 at an edge. If set and clear occur on the same edge, set wins.
- Simultaneous write and read-pointer advance: the level is unchanged and wfull is computed from both new values. A write accepted at level DEPTH-1 while the read pointer advances gives level DEPTH-1 and wfull=0.
- wq2_rptr is treated as legal gray code; no validity checking is performed.

Test Plan (ADDRSIZE=4, DEPTH=16, AFULL_RST=14):
- Reset then idle, wq2_rptr=0:
  - wptr=0, waddr=0, wlevel=0, wfull=0, wafull=0, woverflow=0.
  - Asserting wrst mid-stream with wlevel=9 clears everything immediately, without a clock.
- 16 consecutive winc pulses with rptr held at 0:
  - wlevel counts 1..16.
  - wafull rises at the edge giving level 14.
  - wfull rises at the edge giving level 16, with wptr=5'b11000 and waddr=0.
- Full plus a 17th winc:
  - wptr is unchanged and woverflow=1.
  - woverflow holds; wovf_clr together with a further winc keeps it 1; wovf_clr alone clears it at the next edge.
- Wrap-around: fill and drain 40 entries with the read pointer trailing by 3.
  - wbin wraps 31->0.
  - wlevel stays 3 throughout with no false wfull.
  - wptr matches the gray encoding at every step.
- Threshold load: wafull_thresh=4 with wthresh_ld at level 3 -> wafull=0; the next write -> wafull=1.
  - Loading 0 gives wafull=1 at level 0; loading 17 gives wafull=0 at level 16.
- Simultaneous events at level 15: winc=1 while wq2_rptr advances by one gray step -> wlevel=15, wfull=0, and waddr increments.

Source files
------------

// File: rtl/wptr_full_level.sv
// Write-side pointer and flag generator for an async FIFO.
// Keeps the binary and gray write pointers. From the synchronised gray read
// pointer it derives the registered full flag, the fill level, a programmable
// almost-full flag and a sticky overflow flag.
module wptr_full_level #(
  parameter int ADDRSIZE  = 4,
  parameter int AFULL_RST = 2**ADDRSIZE - 2
) (
  input  logic                wclk,
  input  logic                wrst,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  input  logic [ADDRSIZE:0]   wafull_thresh,
  input  logic                wthresh_ld,
  input  logic                wovf_clr,
  output logic                wfull,
  output logic                wafull,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                woverflow,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr
);

  localparam logic [ADDRSIZE:0] THR_RST = (ADDRSIZE+1)'(AFULL_RST);

  logic [ADDRSIZE:0] wbin;
  logic [ADDRSIZE:0] thr;
  logic [ADDRSIZE:0] rbin;
  logic [ADDRSIZE:0] wbinnext;
  logic [ADDRSIZE:0] wgraynext;
  logic [ADDRSIZE:0] levnext;
  logic              wacc;
  logic              wfull_next;
  logic              wafull_next;

  // Decode the synchronised gray read pointer: each binary bit is the XOR of
  // that gray bit and every bit above it.
  always_comb begin
    // NOTE: every combinational output gets a default before any conditional
    // logic, so no path can leave it unassigned and infer a latch.
    rbin = '0;
    for (int i = 0; i <= ADDRSIZE; i++) begin
      rbin[i] = ^(wq2_rptr >> i);
    end
  end

  // Next pointer, level and flag values, all describing the state after this
  // edge's write (if one is accepted).
  always_comb begin
    wacc        = winc & ~wfull;
    wbinnext    = wbin + {{ADDRSIZE{1'b0}}, wacc};
    wgraynext   = (wbinnext >> 1) ^ wbinnext;
    levnext     = wbinnext - rbin;
    // Full when the pointers differ only in the two MSBs of the gray code,
    // i.e. the write side is exactly one lap ahead.
    wfull_next  = (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1],
                                 wq2_rptr[ADDRSIZE-2:0]});
    wafull_next = (levnext >= thr);
  end

  // Pointer, level and flag registers; the threshold register has its own
  // reset value and load enable.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wbin      <= '0;
      wptr      <= '0;
      wlevel    <= '0;
      wfull     <= 1'b0;
      wafull    <= 1'b0;
      woverflow <= 1'b0;
      thr       <= THR_RST;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      wbin   <= wbinnext;
      wptr   <= wgraynext;
      wlevel <= levnext;
      wfull  <= wfull_next;
      wafull <= wafull_next;
      if (wthresh_ld) thr <= wafull_thresh;
      // A dropped write sets the flag; set wins over a same-edge clear.
      if (winc && wfull)  woverflow <= 1'b1;
      else if (wovf_clr)  woverflow <= 1'b0;
    end
  end

  assign waddr = wbin[ADDRSIZE-1:0];

endmodule

// File: tb/tb_wptr_full_level.sv
// Directed bench for wptr_full_level (ADDRSIZE=4, DEPTH=16, AFULL_RST=14).
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
module tb_wptr_full_level;

  logic       wclk = 1'b0;
  logic       wrst;
  logic       winc;
  logic [4:0] wq2_rptr;
  logic [4:0] wafull_thresh;
  logic       wthresh_ld;
  logic       wovf_clr;
  logic       wfull;
  logic       wafull;
  logic [4:0] wlevel;
  logic       woverflow;
  logic [3:0] waddr;
  logic [4:0] wptr;

  int checks = 0;
  int errors = 0;

  wptr_full_level #(.ADDRSIZE(4), .AFULL_RST(14)) dut (
    .wclk          (wclk),
    .wrst          (wrst),
    .winc          (winc),
    .wq2_rptr      (wq2_rptr),
    .wafull_thresh (wafull_thresh),
    .wthresh_ld    (wthresh_ld),
    .wovf_clr      (wovf_clr),
    .wfull         (wfull),
    .wafull        (wafull),
    .wlevel        (wlevel),
    .woverflow     (woverflow),
    .waddr         (waddr),
    .wptr          (wptr)
  );

  always #5 wclk = ~wclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] gray(input int b);
    logic [4:0] v;
    v = 5'(b);
    return v ^ (v >> 1);
  endfunction

  // Advance one edge, then settle 1 ns away from it.
  task automatic step();
    @(posedge wclk);
    #1;
  endtask

  task automatic do_reset();
    wrst = 1'b1;
    step();
    wrst = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_wptr"},  32'(wptr),      32'd0);
    check({tag, "_waddr"}, 32'(waddr),     32'd0);
    check({tag, "_lvl"},   32'(wlevel),    32'd0);
    check({tag, "_full"},  32'(wfull),     32'd0);
    check({tag, "_afull"}, 32'(wafull),    32'd0);
    check({tag, "_ovf"},   32'(woverflow), 32'd0);
  endtask

  initial begin
    wrst = 1'b1; winc = 1'b0; wq2_rptr = '0; wafull_thresh = '0;
    wthresh_ld = 1'b0; wovf_clr = 1'b0;
    #2;
    check_zero("rst");
    step(); step();
    wrst = 1'b0;
    step();
    check_zero("idle");

    // Fill 16 entries with the read pointer at 0.
    for (int i = 1; i <= 16; i++) begin
      winc = 1'b1;
      step();
      check($sformatf("fill%0d_lvl", i),   32'(wlevel), 32'(i));
      check($sformatf("fill%0d_afull", i), 32'(wafull), 32'(i >= 14));
      check($sformatf("fill%0d_full", i),  32'(wfull),  32'(i == 16));
      check($sformatf("fill%0d_wptr", i),  32'(wptr),   32'(gray(i)));
      check($sformatf("fill%0d_waddr", i), 32'(waddr),  32'(i % 16));
    end
    check("full_wptr_lit", 32'(wptr), 32'b11000);

    // 17th write while full is dropped and flagged.
    winc = 1'b1;
    step();
    check("ovf_wptr", 32'(wptr),      32'b11000);
    check("ovf_lvl",  32'(wlevel),    32'd16);
    check("ovf_set",  32'(woverflow), 32'd1);
    winc = 1'b0;
    step();
    check("ovf_hold", 32'(woverflow), 32'd1);
    winc = 1'b1; wovf_clr = 1'b1;
    step();
    check("ovf_setwins", 32'(woverflow), 32'd1);
    winc = 1'b0;
    step();
    check("ovf_clr", 32'(woverflow), 32'd0);
    wovf_clr = 1'b0;

    // Mid-stream asynchronous reset at level 9.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      winc = 1'b1;
      step();
    end
    winc = 1'b0;
    check("mid_lvl9", 32'(wlevel), 32'd9);
    #2 wrst = 1'b1;
    #1;
    check_zero("async");
    step();
    wrst = 1'b0;

    // Wrap-around: 3 ahead, then write while the read pointer trails by 3.
    for (int i = 0; i < 3; i++) begin
      winc = 1'b1;
      step();
    end
    check("wrap_pre_lvl", 32'(wlevel), 32'd3);
    for (int j = 1; j <= 40; j++) begin
      winc = 1'b1;
      wq2_rptr = gray(j % 32);
      step();
      check($sformatf("wrap%0d_lvl", j),   32'(wlevel), 32'd3);
      check($sformatf("wrap%0d_full", j),  32'(wfull),  32'd0);
      check($sformatf("wrap%0d_wptr", j),  32'(wptr),   32'(gray((3 + j) % 32)));
      check($sformatf("wrap%0d_waddr", j), 32'(waddr),  32'((3 + j) % 16));
    end
    // Drain: read pointer catches up with wbin=11.
    winc = 1'b0;
    wq2_rptr = gray(11);
    step();
    check("drain_lvl", 32'(wlevel), 32'd0);
    check("drain_afull", 32'(wafull), 32'd0);

    // Threshold load of 4 at level 3.
    for (int i = 0; i < 3; i++) begin
      winc = 1'b1;
      step();
    end
    winc = 1'b0; wafull_thresh = 5'd4; wthresh_ld = 1'b1;
    step();
    wthresh_ld = 1'b0;
    check("thr4_lvl3_lvl", 32'(wlevel), 32'd3);
    check("thr4_lvl3_afull", 32'(wafull), 32'd0);
    winc = 1'b1;
    step();
    winc = 1'b0;
    check("thr4_lvl4_lvl", 32'(wlevel), 32'd4);
    check("thr4_lvl4_afull", 32'(wafull), 32'd1);

    // Threshold 0 at level 0 (wbin=15).
    wq2_rptr = gray(15); wafull_thresh = 5'd0; wthresh_ld = 1'b1;
    step();
    wthresh_ld = 1'b0;
    check("thr0_first_afull", 32'(wafull), 32'd0);
    step();
    check("thr0_lvl", 32'(wlevel), 32'd0);
    check("thr0_afull", 32'(wafull), 32'd1);

    // Threshold 17, fill to 16.
    wafull_thresh = 5'd17; wthresh_ld = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      winc = 1'b1;
      step();
      wthresh_ld = 1'b0;
    end
    winc = 1'b0;
    check("thr17_lvl", 32'(wlevel), 32'd16);
    check("thr17_full", 32'(wfull), 32'd1);
    check("thr17_afull", 32'(wafull), 32'd0);

    // Simultaneous write and read advance at level 15.
    do_reset();
    wq2_rptr = '0;
    for (int i = 0; i < 15; i++) begin
      winc = 1'b1;
      step();
    end
    check("sim_pre_lvl", 32'(wlevel), 32'd15);
    check("sim_pre_waddr", 32'(waddr), 32'd15);
    winc = 1'b1; wq2_rptr = gray(1);
    step();
    winc = 1'b0;
    check("sim_lvl", 32'(wlevel), 32'd15);
    check("sim_full", 32'(wfull), 32'd0);
    check("sim_waddr", 32'(waddr), 32'd0);
    check("sim_wptr", 32'(wptr), 32'(gray(16)));
    // Read-only advance lowers the level at the next edge.
    wq2_rptr = gray(2);
    step();
    check("rd_only_lvl", 32'(wlevel), 32'd14);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
